// File: rtl/wb_dsp_equation_sequencer.sv
// Wishbone-driven equation sequencer: fetches a 4-word descriptor, dispatches it to a
// DSP engine, waits for the result with a timeout, and writes the result back.
module wb_dsp_equation_sequencer #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [dw-1:0] equation_address_reg,
    input  logic [dw-1:0] control_reg,
    output logic [dw-1:0] status_reg,
    output logic [aw-1:0] m_wb_adr_o,
    output logic [dw-1:0] m_wb_dat_o,
    output logic [3:0]    m_wb_sel_o,
    output logic          m_wb_we_o,
    output logic          m_wb_cyc_o,
    output logic          m_wb_stb_o,
    output logic [2:0]    m_wb_cti_o,
    output logic [1:0]    m_wb_bte_o,
    input  logic [dw-1:0] m_wb_dat_i,
    input  logic          m_wb_ack_i,
    input  logic          m_wb_err_i,
    output logic [7:0]    eq_type,
    output logic [dw-1:0] eq_src,
    output logic [dw-1:0] eq_dst,
    output logic [15:0]   eq_len,
    output logic          eq_start,
    input  logic          eq_done,
    input  logic [dw-1:0] eq_result,
    output logic          interrupt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DISPATCH  = 3'd2,
        ST_WAIT      = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_COMPLETE  = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic          start_prev;
    logic [dw-1:0] base_q;
    logic [1:0]    word_idx;
    logic [15:0]   wait_cnt;
    logic          bus_q, bus_d;
    logic          done_q, err_q, irq_q;

    logic start_edge, abort, ack_v, err_v, take_ack, timeout_hit;
    logic unused_ctrl;

    assign start_edge  = control_reg[0] & ~start_prev;
    assign abort       = control_reg[2];
    // Bus responses only count while a strobe is actually outstanding.
    assign ack_v       = bus_q & m_wb_ack_i;
    assign err_v       = bus_q & m_wb_err_i;
    assign take_ack    = ack_v & ~err_v & ~abort;
    assign timeout_hit = (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT));
    assign unused_ctrl = ^control_reg[dw-1:3];

    assign m_wb_cyc_o = bus_q;
    assign m_wb_stb_o = bus_q;
    assign m_wb_sel_o = bus_q ? 4'hF : 4'h0;
    assign m_wb_cti_o = '0;
    assign m_wb_bte_o = '0;
    assign interrupt  = irq_q;

    always_comb begin
        state_d  = state_q;
        bus_d    = 1'b0;
        eq_start = (state_q == ST_DISPATCH);
        case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (abort || err_v)  state_d = ST_ERROR;
                else if (ack_v) begin
                    if (word_idx == 2'd3) state_d = ST_DISPATCH;
                end
                else                 bus_d = 1'b1;
            end
            ST_DISPATCH: begin
                state_d = abort ? ST_ERROR : ST_WAIT;
            end
            ST_WAIT: begin
                // Priority: abort, then eq_done, then timeout.
                if (abort)            state_d = ST_ERROR;
                else if (eq_done)     state_d = ST_WRITEBACK;
                else if (timeout_hit) state_d = ST_ERROR;
            end
            ST_WRITEBACK: begin
                if (abort || err_v) state_d = ST_ERROR;
                else if (ack_v)     state_d = ST_COMPLETE;
                else                bus_d = 1'b1;
            end
            ST_COMPLETE: begin
                state_d = abort ? ST_ERROR : ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        status_reg       = '0;
        status_reg[0]    = (state_q != ST_IDLE);
        status_reg[1]    = done_q;
        status_reg[2]    = err_q;
        status_reg[6:4]  = state_q;
        status_reg[15:8] = eq_type;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q    <= ST_IDLE;
            start_prev <= 1'b0;
            base_q     <= '0;
            word_idx   <= '0;
            wait_cnt   <= '0;
            bus_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_we_o  <= 1'b0;
            eq_type    <= '0;
            eq_src     <= '0;
            eq_dst     <= '0;
            eq_len     <= '0;
        end else begin
            state_q    <= state_d;
            start_prev <= control_reg[0];
            bus_q      <= bus_d;
            wait_cnt   <= (state_q == ST_WAIT) ? wait_cnt + 16'd1 : '0;

            if (state_q == ST_IDLE && start_edge) begin
                base_q   <= equation_address_reg;
                word_idx <= '0;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                irq_q    <= 1'b0;
            end

            // Address and direction are set up on the cycle the strobe rises.
            if (bus_d && !bus_q) begin
                if (state_q == ST_WRITEBACK) begin
                    m_wb_adr_o <= aw'(base_q) + aw'(5'h10);
                    m_wb_we_o  <= 1'b1;
                end else begin
                    m_wb_adr_o <= aw'(base_q) + aw'({word_idx, 2'b00});
                    m_wb_we_o  <= 1'b0;
                end
            end

            if (state_q == ST_FETCH && take_ack) begin
                case (word_idx)
                    2'd0: begin
                        eq_type <= m_wb_dat_i[7:0];
                        eq_len  <= m_wb_dat_i[31:16];
                    end
                    2'd1:    eq_src <= m_wb_dat_i;
                    2'd2:    eq_dst <= m_wb_dat_i;
                    default: ;
                endcase
                word_idx <= word_idx + 2'd1;
            end

            if (state_q == ST_WAIT && eq_done && !abort)
                m_wb_dat_o <= eq_result;

            if (state_d == ST_COMPLETE && state_q != ST_COMPLETE) begin
                done_q <= 1'b1;
                if (control_reg[1]) irq_q <= 1'b1;
            end
            if (state_d == ST_ERROR && state_q != ST_ERROR) begin
                err_q <= 1'b1;
                if (control_reg[1]) irq_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/wb_dsp_equation_sequencer.md
WB_DSP_EQUATION_SEQUENCER -- requirements
Module: wb_dsp_equation_sequencer

Interface
REQ-001 Parameter dw, 32, data width of the slave registers and master bus.
REQ-002 Parameter aw, 32, master bus address width.
REQ-003 Parameter TIMEOUT, 1024, maximum cycles waiting for eq_done before an error is declared; legal range is 1 to 65535.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: wb_clk in 1 clock; wb_rst in 1 reset.
REQ-005 equation_address_reg in dw: byte address of the 4-word equation descriptor, word-aligned.
REQ-006 control_reg in dw: bit0 START, bit1 IRQ_EN, bit2 ABORT; all other bits are ignored.
REQ-007 status_reg out dw: bit0 BUSY, bit1 DONE, bit2 ERROR, bits[6:4] state code, bits[15:8] equation type, all other bits 0.
REQ-008 Master bus outputs: m_wb_adr_o aw, m_wb_dat_o dw, m_wb_sel_o 4, m_wb_we_o 1, m_wb_cyc_o 1, m_wb_stb_o 1, m_wb_cti_o 3 (always 3'b000), m_wb_bte_o 2 (always 2'b00).
REQ-009 Master bus inputs: m_wb_dat_i dw, m_wb_ack_i 1, m_wb_err_i 1.
REQ-010 Engine outputs: eq_type out 8; eq_src out dw; eq_dst out dw; eq_len out 16; eq_start out 1 (one-cycle pulse).
REQ-011 Engine inputs: eq_done in 1 (one-cycle pulse); eq_result in dw.
REQ-012 interrupt out 1: level signal, set on completion or error.

Function
REQ-013 States and codes: IDLE=0, FETCH=1, DISPATCH=2, WAIT=3, WRITEBACK=4, COMPLETE=5, ERROR=6.
REQ-014 A START rising edge (bit0 was 0 on the previous cycle and is 1 now) in IDLE SHALL clear DONE, ERROR and interrupt, latch equation_address_reg into base, and enter FETCH on the next cycle.
REQ-015 A START that is held high SHALL NOT retrigger; START edges outside IDLE SHALL be ignored.
REQ-016 FETCH SHALL perform 4 single classic-cycle reads at base+0, +4, +8, +C, with m_wb_sel_o=4'hF and m_wb_we_o=0.
REQ-017 Read mapping: word0[7:0] -> eq_type, word0[31:16] -> eq_len, word1 -> eq_src, word2 -> eq_dst; word3 is reserved and discarded.
REQ-018 cyc/stb SHALL be asserted from the cycle after state entry until the cycle of ack; stb SHALL deassert for exactly 1 cycle between accesses.
REQ-019 After the 4th ack, the block SHALL enter DISPATCH, drive eq_start high for exactly 1 cycle, then enter WAIT.
REQ-020 In WAIT, a 16-bit counter SHALL increment each cycle; eq_done moves to WRITEBACK and captures eq_result.
REQ-021 If the counter reaches TIMEOUT without eq_done, the block SHALL enter ERROR.
REQ-022 eq_done arriving on the same cycle the counter reaches TIMEOUT SHALL win, and the block SHALL move to WRITEBACK.
REQ-023 WRITEBACK SHALL perform one single write of the captured result to base+0x10, with m_wb_sel_o=4'hF and m_wb_we_o=1; on ack the block SHALL enter COMPLETE.
REQ-024 COMPLETE SHALL set DONE for 1 cycle of state, then return to IDLE; DONE SHALL stay set until the next START.
REQ-025 m_wb_err_i during any access SHALL terminate the cycle (cyc/stb low the next cycle) and enter ERROR.
REQ-026 ERROR SHALL set the ERROR bit and return to IDLE after 1 cycle; the ERROR bit SHALL stay set until the next START.
REQ-027 ABORT=1 in any non-IDLE state SHALL drop cyc/stb the next cycle and enter ERROR.
REQ-028 ABORT SHALL override a simultaneous ack, eq_done and timeout.
REQ-029 interrupt SHALL be set on entry to COMPLETE or ERROR when IRQ_EN=1, and cleared only by the next START or by reset.
REQ-030 BUSY SHALL be 1 in every state except IDLE.
REQ-031 Address arithmetic SHALL be modulo 2^aw; base+0x10 wrapping past all-ones is legal.
REQ-032 An eq_len of 0 SHALL still dispatch; the engine defines its meaning.
REQ-033 An ack that arrives while stb is low SHALL be ignored.

Reset
REQ-034 wb_rst SHALL force IDLE and clear all outputs to 0 on the next clock edge, including cyc/stb mid-transfer, status_reg, interrupt and the eq_* registers.
REQ-035 The internal START-edge history register and the timeout counter SHALL be cleared to 0 by reset.
REQ-036 START held high through the deassertion of wb_rst SHALL count as a rising edge.

Verification
REQ-037 Nominal: descriptor at 0x100 = {0x0010_0003, 0x200, 0x300, x}, START 0->1, IRQ_EN=1, engine returns 0xCAFE after 5 cycles -> 4 reads at 0x100..0x10C, eq_type=3, eq_len=16, one eq_start pulse, write of 0xCAFE to 0x110, status=0x0000_0302, interrupt=1.
REQ-038 Bus error on the 2nd read -> no eq_start, status ERROR=1 BUSY=0, interrupt=1 if IRQ_EN=1.
REQ-039 TIMEOUT=8, no eq_done -> ERROR entered exactly 8 cycles after WAIT entry; no write cycle issued.
REQ-040 ABORT asserted during WAIT together with eq_done -> ERROR, no writeback.
REQ-041 START held high after COMPLETE -> no second run; START dropped then raised again -> second run, DONE cleared at the start.
REQ-042 wb_rst pulsed during the 3rd read -> cyc=0 next cycle, all outputs 0, and a subsequent START runs normally.
